// File: rtl/hm01b0_mcu_reader.sv
// Drains one 8-row stripe from an EBR buffer half and emits it as 8x8 MCUs.
// Optional: define HM01B0_MCU_READER_STALL_COUNT_EN to add o_stall_cycles.
module hm01b0_mcu_reader #(
  parameter int WIDTH_PIX = 320,
  parameter int NUM_EBR   = 5,
  parameter int EBR_SIZE  = 512,
  localparam int BLK_W    = $clog2(NUM_EBR),
  localparam int ADDR_W   = $clog2(EBR_SIZE),
  localparam int SLOT_W   = ADDR_W - 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_stripe_start,
  input  logic              i_stripe_buffer,
  output logic [BLK_W-1:0]  o_ebr_block_select,
  output logic              o_ebr_buffer_select,
  output logic [ADDR_W-1:0] o_ebr_read_addr,
  output logic              o_ebr_rden,
  input  logic [7:0]        i_ebr_read_data,
  output logic [7:0]        o_pixel_out,
  output logic              o_pixel_valid,
  input  logic              i_pixel_ready,
  output logic              o_mcu_first,
  output logic              o_mcu_last,
  output logic              o_stripe_done,
  output logic              o_busy,
  output logic              o_overrun,
`ifdef HM01B0_MCU_READER_STALL_COUNT_EN
  output logic [15:0]       o_stall_cycles,
`endif
  output logic [1:0]        o_dbg_state
);

  localparam int NUM_MCU   = WIDTH_PIX / 8;
  localparam int LAST_BLK  = (NUM_MCU - 1) % NUM_EBR;
  localparam int LAST_SLOT = (NUM_MCU - 1) / NUM_EBR;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2:0]        r_px, r_py;
  logic [BLK_W-1:0]  r_blk, r_last_blk;
  logic [SLOT_W-1:0] r_slot;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_buf, r_inflight, r_tag_first, r_tag_last, r_overrun;
  logic [9:0]        r_fifo [2];
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;

  logic       w_rden, w_pop, w_push, w_at_end, w_done, w_accept, w_valid;
  logic [2:0] w_occ;
  logic [9:0] w_head;

  // Output handshake: a pixel transfers on a rising edge where o_pixel_valid
  // and i_pixel_ready are both high; while valid && !ready the head is frozen.
  assign w_valid  = (r_count != 2'd0);
  assign w_pop    = w_valid && i_pixel_ready;
  assign w_push   = r_inflight;
  // Credit the pop happening this cycle so a full-rate stream never bubbles.
  assign w_occ    = 3'({1'b0, r_count}) + 3'(r_inflight) - 3'(w_pop);
  assign w_at_end = (r_px == 3'd7) && (r_py == 3'd7) &&
                    (r_blk == BLK_W'(LAST_BLK)) && (r_slot == SLOT_W'(LAST_SLOT));
  assign w_done   = (r_state == S_DRAIN) && (r_count == 2'd0) && !r_inflight;
  assign w_accept = i_stripe_start && ((r_state == S_IDLE) || w_done);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rden      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ: begin
        if (w_occ < 3'd2) begin
          w_rden = 1'b1;
          if (w_at_end) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (w_done) w_state_nxt = w_accept ? S_READ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ripple address counter px -> py -> block -> slot.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_px        <= '0;
      r_py        <= '0;
      r_blk       <= '0;
      r_slot      <= '0;
      r_last_addr <= '0;
      r_last_blk  <= '0;
      r_buf       <= 1'b0;
      r_inflight  <= 1'b0;
      r_tag_first <= 1'b0;
      r_tag_last  <= 1'b0;
    end else begin
      r_inflight <= w_rden;
      if (w_accept) begin
        r_px   <= '0;
        r_py   <= '0;
        r_blk  <= '0;
        r_slot <= '0;
        r_buf  <= i_stripe_buffer;
      end else if (w_rden) begin
        r_last_addr <= {r_slot, r_py, r_px};
        r_last_blk  <= r_blk;
        r_tag_first <= (r_px == 3'd0) && (r_py == 3'd0);
        r_tag_last  <= (r_px == 3'd7) && (r_py == 3'd7);
        r_px        <= r_px + 3'd1;
        if (r_px == 3'd7) begin
          r_py <= r_py + 3'd1;
          if (r_py == 3'd7) begin
            if (r_blk == BLK_W'(NUM_EBR - 1)) begin
              r_blk  <= '0;
              r_slot <= r_slot + 1'b1;
            end else begin
              r_blk <= r_blk + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {r_tag_first, r_tag_last, i_ebr_read_data};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                          r_overrun <= 1'b0;
    else if (i_stripe_start && !w_accept) r_overrun <= 1'b1;
  end

`ifdef HM01B0_MCU_READER_STALL_COUNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)        r_stall <= '0;
    else if (w_accept)  r_stall <= '0;
    else if (w_valid && !i_pixel_ready && (r_stall != 16'hFFFF))
                        r_stall <= r_stall + 16'd1;
  end
  assign o_stall_cycles = r_stall;
`endif

  assign w_head              = r_fifo[r_rptr];
  assign o_pixel_out         = w_head[7:0];
  assign o_mcu_first         = w_valid && w_head[9];
  assign o_mcu_last          = w_valid && w_head[8];
  assign o_pixel_valid       = w_valid;
  assign o_ebr_rden          = w_rden;
  assign o_ebr_read_addr     = w_rden ? {r_slot, r_py, r_px} : r_last_addr;
  assign o_ebr_block_select  = w_rden ? r_blk : r_last_blk;
  assign o_ebr_buffer_select = r_buf;
  assign o_stripe_done       = w_done;
  assign o_busy              = (r_state != S_IDLE);
  assign o_overrun           = r_overrun;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_hm01b0_mcu_reader.sv
// Scoreboard bench for hm01b0_mcu_reader: expected MCU pixel stream queued at
// stripe start, popped and compared by a monitor on every accepted pixel.
module tb_hm01b0_mcu_reader;

  localparam int NPIX = 2560;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sbuf = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] ebr_data = 8'd0;
  logic [2:0] blk_sel;
  logic       buf_sel;
  logic [8:0] rd_addr;
  logic       rden;
  logic [7:0] pix;
  logic       valid, first, last, done, busy, overrun;
  logic [1:0] dbg_state;
`ifdef HM01B0_MCU_READER_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  hm01b0_mcu_reader dut (
    .i_clock(clk), .i_reset(rst), .i_stripe_start(start), .i_stripe_buffer(sbuf),
    .o_ebr_block_select(blk_sel), .o_ebr_buffer_select(buf_sel),
    .o_ebr_read_addr(rd_addr), .o_ebr_rden(rden), .i_ebr_read_data(ebr_data),
    .o_pixel_out(pix), .o_pixel_valid(valid), .i_pixel_ready(ready),
    .o_mcu_first(first), .o_mcu_last(last), .o_stripe_done(done),
    .o_busy(busy), .o_overrun(overrun),
`ifdef HM01B0_MCU_READER_STALL_COUNT_EN
    .o_stall_cycles(stall_cycles),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / EBR model
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rden) ebr_data <= rd_addr[7:0] ^ {2'b00, blk_sel, 3'b000};

  int n_vec = 0, n_fail = 0;
  int n_acc = 0, n_done = 0, n_first = 0, n_last = 0;
  int out_cnt = 0, rd_idx = 0;
  bit chk469 = 1'b0, rand_ready = 1'b0, stall_hold = 1'b0;
  logic [9:0] hold_val;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: expected stream for one stripe, built directly from MCU order
  task automatic push_stripe();
    for (int m = 0; m < 40; m++)
      for (int py = 0; py < 8; py++)
        for (int px = 0; px < 8; px++) begin
          int a;
          logic [7:0] d;
          a = (m / 5) * 64 + py * 8 + px;
          d = 8'(a) ^ 8'((m % 5) << 3);
          exp_q.push_back({(py == 0 && px == 0), (py == 7 && px == 7), d});
        end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        out_cnt    = 0;
        stall_hold = 1'b0;
      end else begin
        logic pop;
        pop = valid && ready;
        check("outstanding", (out_cnt + int'(rden) - int'(pop) <= 2), 1);
        out_cnt = out_cnt + int'(rden) - int'(pop);
        if (rden) begin
          if (chk469 && rd_idx == 469) begin
            check("mcu7_r2_c5_block", blk_sel, 2);
            check("mcu7_r2_c5_addr", rd_addr, 85);
          end
          rd_idx++;
        end
        if (stall_hold) check("hold", {valid, first, last, pix}, {1'b1, hold_val});
        stall_hold = valid && !ready;
        hold_val   = {first, last, pix};
        if (pop) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", {first, last, pix}, -1);
          end else begin
            check("pixel", {first, last, pix}, exp_q.pop_front());
          end
          n_acc++;
          if (first) n_first++;
          if (last)  n_last++;
        end
        if (done) n_done++;
      end
    end
  endtask

  task automatic ready_src();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = ($urandom_range(0, 99) < 30);
    end
  endtask

  task automatic start_stripe(input logic b);
    @(posedge clk); #1;
    start = 1'b1;
    sbuf  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_acc(input int base, input int n, input int budget, input string name);
    int c = 0;
    while ((n_acc - base) < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check(name, n_acc - base, n);
  endtask

  task automatic wait_done(input int base, input int n, input int budget, input string name);
    int c = 0;
    while ((n_done - base) < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check(name, n_done - base, n);
  endtask

  initial begin
    int ba, bd, bf, bl, quiet;
    fork
      monitor();
      ready_src();
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rden_valid_busy", {rden, valid, busy, done, overrun, first, last}, 0);
    check("reset_addr_blk_buf", {rd_addr, blk_sel, buf_sel, pix}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: full stripe, buffer 1, ready high
    ba = n_acc; bd = n_done; bf = n_first; bl = n_last;
    chk469 = 1'b1;
    rd_idx = 0;
    push_stripe();
    start_stripe(1'b1);
    @(negedge clk);
    check("t1_rden_n1", rden, 1);
    check("t1_addr_n1", {blk_sel, rd_addr}, 0);
    check("t1_bufsel", buf_sel, 1);
    check("t1_busy_n1", busy, 1);
    check("t1_valid_n1", valid, 0);
    @(negedge clk);
    check("t1_valid_n2", valid, 0);
    @(negedge clk);
    check("t1_valid_n3", valid, 1);
    wait_done(bd, 1, 4000, "t1_done");
    repeat (3) @(negedge clk);
    chk469 = 1'b0;
    check("t1_read_count", rd_idx, NPIX);
    check("t1_pixels", n_acc - ba, NPIX);
    check("t1_first_cnt", n_first - bf, 40);
    check("t1_last_cnt", n_last - bl, 40);
    check("t1_done_pulses", n_done - bd, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_idle", {busy, overrun}, 0);

    // T2: random 30% ready
    ba = n_acc; bd = n_done;
    push_stripe();
    rand_ready = 1'b1;
    start_stripe(1'b0);
    @(negedge clk);
    check("t2_bufsel", buf_sel, 0);
    wait_done(bd, 1, 20000, "t2_done");
    rand_ready = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    check("t2_pixels", n_acc - ba, NPIX);
    check("t2_queue_empty", exp_q.size(), 0);

    // T3: overrun at pixel 100
    ba = n_acc; bd = n_done;
    push_stripe();
    start_stripe(1'b1);
    wait_acc(ba, 100, 500, "t3_reach_100");
    start_stripe(1'b0);
    @(negedge clk);
    check("t3_overrun_set", overrun, 1);
    check("t3_bufsel_kept", buf_sel, 1);
    wait_done(bd, 1, 4000, "t3_done");
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (rden || busy) quiet++;
    end
    check("t3_no_second_stripe", quiet, 0);
    check("t3_pixels", n_acc - ba, NPIX);
    check("t3_overrun_sticky", overrun, 1);

    // T4: start coincident with stripe_done
    ba = n_acc; bd = n_done;
    push_stripe();
    start_stripe(1'b1);
    wait_acc(ba, NPIX, 4000, "t4_stripe_a");
    @(posedge clk); #1;
    start = 1'b1;
    sbuf  = 1'b0;
    push_stripe();
    @(negedge clk);
    check("t4_done_coincident", {done, busy}, 3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t4_rden_next", rden, 1);
    check("t4_addr_blk_zero", {blk_sel, rd_addr}, 0);
    check("t4_busy_kept", busy, 1);
    check("t4_bufsel", buf_sel, 0);
    wait_done(bd, 2, 8000, "t4_done_b");
    check("t4_pixels", n_acc - ba, 2 * NPIX);
    check("t4_queue_empty", exp_q.size(), 0);

    // T5: reset at pixel 1000
    ba = n_acc;
    push_stripe();
    start_stripe(1'b1);
    wait_acc(ba, 1000, 2000, "t5_reach_1000");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    bd = n_done;
    @(negedge clk);
    check("t5_reset_ctrl", {rden, valid, busy, done, overrun, first, last}, 0);
    check("t5_reset_addr", {rd_addr, blk_sel, buf_sel, pix}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_done_aborted", n_done - bd, 0);
    check("t5_idle_after_reset", busy, 0);
    ba = n_acc; bf = n_first;
    push_stripe();
    start_stripe(1'b0);
    wait_done(bd, 1, 4000, "t5_done_fresh");
    check("t5_pixels", n_acc - ba, NPIX);
    check("t5_first_cnt", n_first - bf, 40);
    check("t5_queue_empty", exp_q.size(), 0);

`ifdef HM01B0_MCU_READER_STALL_COUNT_EN
    // T6: 50 stalled cycles mid-stripe
    ba = n_acc; bd = n_done;
    push_stripe();
    start_stripe(1'b1);
    wait_acc(ba, 500, 1000, "t6_reach_500");
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done(bd, 1, 4000, "t6_done");
    check("t6_stall_cycles", stall_cycles, 50);
    bd = n_done;
    push_stripe();
    start_stripe(1'b0);
    @(negedge clk);
    check("t6_stall_cleared", stall_cycles, 0);
    wait_done(bd, 1, 4000, "t6_done2");
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
